// File: rtl/bit_serializer.sv
// MSB-first word serializer with a one-word holding buffer, feeding the 11001 sequence detector.
// Each bit is held for DIV clocks; a buffered or coincident start continues with zero gap.
module bit_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             x,
  output logic             bit_valid,
  output logic             busy,
  output logic             ready,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             full_q, full_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]       div_cnt_q, div_cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             bit_end, last_clk;

  assign bit_end  = (div_cnt_q == 8'(DIV - 1));
  assign last_clk = bit_end && (bit_cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    buf_d     = buf_q;
    full_d    = full_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    // A start can only be rejected while a word is already waiting in the buffer.
    ovf_d     = start && full_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d      = data_in;
          state_d   = StShift;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      StShift: begin
        if (start && !full_q && !last_clk) begin
          buf_d  = data_in;
          full_d = 1'b1;
        end
        if (bit_end) begin
          div_cnt_d = '0;
          if (last_clk) begin
            bit_cnt_d = '0;
            if (full_q) begin
              sr_d   = buf_q;
              full_d = 1'b0;
            end else if (start) begin
              sr_d = data_in;
            end else begin
              // Clearing the shift register keeps x low for the whole idle period.
              sr_d    = '0;
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sr_d      = {sr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      buf_q     <= '0;
      full_q    <= 1'b0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      buf_q     <= buf_d;
      full_q    <= full_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign x         = sr_q[WIDTH-1];
  assign busy      = (state_q == StShift);
  assign bit_valid = (state_q == StShift);
  assign ready     = ~full_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule
